// File: rtl/cpu_sequencer_if.sv
// Control bundle between the cpu_sequencer and the datapath/memory side.
// The step input exists only when SINGLE_STEP_EN is defined.
interface cpu_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       instr;
  logic             zero_flag;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_load;
  logic             pc_inc;
  logic             pc_load;
  logic             reg_write;
  logic             wb_sel;
  logic [2:0]       alu_op;
  logic             halted;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_dbg;
`ifdef SINGLE_STEP_EN
  logic             step;

  modport master (
    input  instr, zero_flag, mem_ready, step,
    output mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
           reg_write, wb_sel, alu_op, halted, illegal_op, retired, state_dbg
  );

  modport slave (
    output instr, zero_flag, mem_ready, step,
    input  mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
           reg_write, wb_sel, alu_op, halted, illegal_op, retired, state_dbg
  );
`else
  modport master (
    input  instr, zero_flag, mem_ready,
    output mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
           reg_write, wb_sel, alu_op, halted, illegal_op, retired, state_dbg
  );

  modport slave (
    output instr, zero_flag, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
           reg_write, wb_sel, alu_op, halted, illegal_op, retired, state_dbg
  );
`endif
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 8-bit CPU: fetch/decode/exec/mem/imm with req/ready memory handshake.
// Optional macro SINGLE_STEP_EN adds a step input and a PAUSE state entered after every retire.
module cpu_sequencer #(
  parameter int CNT_W        = 16,
  parameter int ILLEGAL_HALT = 0
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_IMM    = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
`ifdef SINGLE_STEP_EN
  localparam logic [2:0] S_PAUSE  = 3'd7;
  localparam logic [2:0] S_AFTER_RETIRE = S_PAUSE;
`else
  localparam logic [2:0] S_AFTER_RETIRE = S_FETCH;
`endif

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0] opcode;
  logic       mem_ready;
  logic       illegal_halt_en;

  logic       mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
  logic       reg_write, wb_sel, halted, illegal_op, retire;
  logic [2:0] alu_op;

  assign opcode          = bus.instr[7:4];
  assign mem_ready       = bus.mem_ready;
  assign illegal_halt_en = (ILLEGAL_HALT != 0);

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_JMP, OP_BEQ:
                          state_d = S_AFTER_RETIRE;
          OP_LDI:         state_d = S_IMM;
          OP_LD, OP_ST:   state_d = S_MEM;
          OP_HALT:        state_d = S_HALT;
          default:        state_d = illegal_halt_en ? S_HALT : S_AFTER_RETIRE;
        endcase
      end
      S_IMM:    if (mem_ready) state_d = S_AFTER_RETIRE;
      S_MEM:    if (mem_ready) state_d = S_AFTER_RETIRE;
      S_HALT:   state_d = S_HALT;
`ifdef SINGLE_STEP_EN
      S_PAUSE:  if (bus.step) state_d = S_FETCH;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state plus live instr/zero_flag/mem_ready
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    illegal_op = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
      end
      S_EXEC: begin
        case (opcode)
          OP_NOP: retire = 1'b1;
          OP_ADD: begin alu_op = ALU_ADD; reg_write = 1'b1; retire = 1'b1; end
          OP_SUB: begin alu_op = ALU_SUB; reg_write = 1'b1; retire = 1'b1; end
          OP_AND: begin alu_op = ALU_AND; reg_write = 1'b1; retire = 1'b1; end
          OP_OR:  begin alu_op = ALU_OR;  reg_write = 1'b1; retire = 1'b1; end
          OP_LDI, OP_LD, OP_ST: retire = 1'b0;
          OP_JMP: begin pc_load = 1'b1;          retire = 1'b1; end
          OP_BEQ: begin pc_load = bus.zero_flag; retire = 1'b1; end
          OP_HALT: retire = 1'b1;
          default: begin illegal_op = 1'b1; retire = 1'b1; end
        endcase
      end
      S_IMM: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          reg_write = 1'b1;
          wb_sel    = 1'b1;
          pc_inc    = 1'b1;
          retire    = 1'b1;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_ST);
        if (mem_ready) begin
          reg_write = (opcode == OP_LD);
          wb_sel    = (opcode == OP_LD);
          retire    = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // Reset masks every output so an abandoned access can never fire a write enable
  assign bus.mem_req    = mem_req    & ~reset;
  assign bus.mem_we     = mem_we     & ~reset;
  assign bus.addr_sel   = addr_sel   & ~reset;
  assign bus.ir_load    = ir_load    & ~reset;
  assign bus.pc_inc     = pc_inc     & ~reset;
  assign bus.pc_load    = pc_load    & ~reset;
  assign bus.reg_write  = reg_write  & ~reset;
  assign bus.wb_sel     = wb_sel     & ~reset;
  assign bus.alu_op     = reset ? 3'b000 : alu_op;
  assign bus.halted     = halted     & ~reset;
  assign bus.illegal_op = illegal_op & ~reset;
  assign bus.retired    = retired_q;
  assign bus.state_dbg  = reset ? 3'b000 : state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed plan items plus a randomized instruction stream,
// checked cycle by cycle against expectations built from the instruction-level rules.
`timescale 1ns/1ps
module tb_cpu_sequencer;

  localparam int CW = 4;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_IMM = 3'd5, ST_HALT = 3'd6, ST_PAUSE = 3'd7;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   model_ret = 0;
  int   txn = 0;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.CNT_W(CW)) bus ();

  cpu_sequencer #(.CNT_W(CW), .ILLEGAL_HALT(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] obs_vec;
  assign obs_vec = {bus.state_dbg, bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_load, bus.pc_inc,
                    bus.pc_load, bus.reg_write, bus.wb_sel, bus.alu_op, bus.halted, bus.illegal_op};

  function automatic logic [15:0] mk(input logic [2:0] st, input logic req, input logic we,
                                     input logic asel, input logic irl, input logic pinc,
                                     input logic pld, input logic rw, input logic wb,
                                     input logic [2:0] alu, input logic hlt, input logic ill);
    return {st, req, we, asel, irl, pinc, pld, rw, wb, alu, hlt, ill};
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      4'h2:    return 3'b001;
      4'h3:    return 3'b010;
      4'h4:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive mem_ready, compare all outputs mid-cycle, advance to just after the edge
  task automatic cyc(input logic rdy, input logic [15:0] exp, input string tag);
    bus.mem_ready = rdy;
    @(negedge clk);
    checks++;
    assert (obs_vec === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_vec, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_retired(input string tag);
    checks++;
    assert (bus.retired === CW'(model_ret)) else begin
      errors++;
      $error("FAIL %s retired observed=%0d expected=%0d", tag, bus.retired, model_ret);
    end
  endtask

  task automatic fetch(input logic [7:0] ib, input int wf, input string tag);
    for (int i = 0; i < wf; i++)
      cyc(N, mk(ST_FETCH, Y, N, N, N, N, N, N, N, 3'b000, N, N), {tag, "_fetch_wait"});
    cyc(Y, mk(ST_FETCH, Y, N, N, Y, Y, N, N, N, 3'b000, N, N), {tag, "_fetch"});
    bus.instr = ib;
    bus.zero_flag = rnd_bit();
    cyc(rnd_bit(), mk(ST_DECODE, N, N, N, N, N, N, N, N, 3'b000, N, N), {tag, "_decode"});
  endtask

  task automatic run_instr(input logic [7:0] ib, input int wf, input int wm, input logic zf,
                           input string tag);
    logic [3:0] op;
    logic [2:0] alu;
    logic rw, pld, ill, we, ld;
    op = ib[7:4];
    fetch(ib, wf, tag);
    bus.zero_flag = zf;
    alu = 3'b000; rw = N; pld = N; ill = N;
    if (op >= 4'h1 && op <= 4'h4) begin alu = alu_of(op); rw = Y; end
    if (op == 4'h8) pld = Y;
    if (op == 4'h9) pld = zf;
    if (op >= 4'hA && op <= 4'hE) ill = Y;
    cyc(rnd_bit(), mk(ST_EXEC, N, N, N, N, N, pld, rw, N, alu, N, ill), {tag, "_exec"});
    if (op == 4'h5) begin
      for (int i = 0; i < wm; i++)
        cyc(N, mk(ST_IMM, Y, N, N, N, N, N, N, N, 3'b000, N, N), {tag, "_imm_wait"});
      cyc(Y, mk(ST_IMM, Y, N, N, N, Y, N, Y, Y, 3'b000, N, N), {tag, "_imm"});
    end else if (op == 4'h6 || op == 4'h7) begin
      we = (op == 4'h7);
      ld = (op == 4'h6);
      for (int i = 0; i < wm; i++)
        cyc(N, mk(ST_MEM, Y, we, Y, N, N, N, N, N, 3'b000, N, N), {tag, "_mem_wait"});
      cyc(Y, mk(ST_MEM, Y, we, Y, N, N, N, ld, ld, 3'b000, N, N), {tag, "_mem"});
    end
    model_ret = (model_ret + 1) % (1 << CW);
    check_retired({tag, "_retired"});
`ifdef SINGLE_STEP_EN
    if (op != 4'hF) begin
      int n;
      n = $urandom_range(0, 2);
      bus.step = 1'b0;
      for (int i = 0; i < n; i++)
        cyc(rnd_bit(), mk(ST_PAUSE, N, N, N, N, N, N, N, N, 3'b000, N, N), {tag, "_pause_hold"});
      bus.step = 1'b1;
      cyc(rnd_bit(), mk(ST_PAUSE, N, N, N, N, N, N, N, N, 3'b000, N, N), {tag, "_pause_step"});
      bus.step = 1'b0;
    end
`endif
    txn++;
    $display("txn %0d %s instr=%h wf=%0d wm=%0d zf=%0d retired=%0d", txn, tag, ib, wf, wm, zf,
             bus.retired);
  endtask

  initial begin
    logic [3:0]  op;
    logic [7:0]  ib;
    bus.instr     = 8'h00;
    bus.zero_flag = 1'b0;
    bus.mem_ready = 1'b1;
`ifdef SINGLE_STEP_EN
    bus.step      = 1'b0;
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) cyc(Y, 16'h0000, "reset_outputs");
    model_ret = 0;
    check_retired("reset_retired");

    reset = 1'b0;
    cyc(Y, mk(ST_IDLE, N, N, N, N, N, N, N, N, 3'b000, N, N), "idle");
    run_instr(8'h16, 0, 0, N, "add_r1_r2");
    run_instr(8'h64, 0, 3, N, "ld_wait3");
    run_instr(8'h90, 1, 0, Y, "beq_taken");
    run_instr(8'h90, 0, 0, N, "beq_not_taken");
    run_instr(8'h52, 2, 1, N, "ldi");
    run_instr(8'h7B, 0, 2, N, "st");
    run_instr(8'hA0, 0, 0, N, "illegal");
    run_instr(8'h2D, 0, 0, N, "sub_after_illegal");

    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 14));
      ib = {op, 4'($urandom_range(0, 15))};
      run_instr(ib, $urandom_range(0, 2), $urandom_range(0, 3), rnd_bit(), "rand");
    end

    // Reset in the middle of a store access: nothing may fire, then restart at IDLE
    fetch(8'h71, 0, "st_abort");
    cyc(rnd_bit(), mk(ST_EXEC, N, N, N, N, N, N, N, N, 3'b000, N, N), "st_abort_exec");
    cyc(N, mk(ST_MEM, Y, Y, Y, N, N, N, N, N, 3'b000, N, N), "st_abort_mem_wait");
    reset = 1'b1;
    cyc(Y, 16'h0000, "st_abort_reset");
    reset = 1'b0;
    model_ret = 0;
    check_retired("st_abort_retired");
    cyc(Y, mk(ST_IDLE, N, N, N, N, N, N, N, N, 3'b000, N, N), "st_abort_idle");
    run_instr(8'h3E, 1, 0, N, "and_after_abort");

    run_instr(8'hF0, 0, 0, N, "halt");
    for (int i = 0; i < 20; i++)
      cyc(1'(i % 2), mk(ST_HALT, N, N, N, N, N, N, N, N, 3'b000, Y, N), "halt_hold");
    check_retired("halt_retired");
    reset = 1'b1;
    cyc(Y, 16'h0000, "halt_reset");
    reset = 1'b0;
    model_ret = 0;
    check_retired("halt_reset_retired");
    cyc(Y, mk(ST_IDLE, N, N, N, N, N, N, N, N, 3'b000, N, N), "halt_restart_idle");
    run_instr(8'h00, 0, 0, N, "nop_after_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
